vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front porch pixels.
REQ-003 Parameter H_SYNC, 96, horizontal sync pulse pixels.
REQ-004 Parameter H_BP, 48, horizontal back porch pixels.
REQ-005 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-006 Parameter V_FP, 10, vertical front porch lines.
REQ-007 Parameter V_SYNC, 2, vertical sync pulse lines.
REQ-008 Parameter V_BP, 33, vertical back porch lines.
REQ-009 Parameter SYNC_POL, 0, asserted level of h_sync/v_sync (0 = active-low).
REQ-010 clk  input  1  single clock; all state updates on rising edge only.
REQ-011 rst  input  1  reset, synchronous and active-high.
REQ-012 pix_en  input  1  pixel-tick enable; counters advance only when high.
REQ-013 x  output  10  registered horizontal counter, 0..H_TOTAL-1.
REQ-014 y  output  10  registered vertical counter, 0..V_TOTAL-1.
REQ-015 frame_active  output  1  high when x<H_ACTIVE and y<V_ACTIVE.
REQ-016 h_sync  output  1  horizontal sync, level per SYNC_POL.
REQ-017 v_sync  output  1  vertical sync, level per SYNC_POL.
REQ-018 line_start  output  1  one-clk pulse when x=0 is presented.
REQ-019 frame_start  output  1  one-clk pulse when (x,y)=(0,0) is presented.
REQ-020 frame_ctr  output  8  completed-frame count, wraps 255->0.

Function
REQ-021 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 default); V_TOTAL likewise (525 default); both SHALL be <=1024.
REQ-022 Internal counters hc, vc: on clk with pix_en=1, hc increments; at hc=H_TOTAL-1 hc wraps to 0 and vc increments; at vc=V_TOTAL-1 with hc wrap, vc wraps to 0.
REQ-023 pix_en=0: counters and x, y, frame_active, h_sync, v_sync, frame_ctr hold; line_start and frame_start drive 0.
REQ-024 Outputs SHALL be registered with exactly one pix_en-qualified cycle latency: on clk with pix_en=1, x<=hc, y<=vc and all decoded outputs load values decoded from the pre-increment (hc,vc).
REQ-025 h_sync asserted for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751 default), else deasserted.
REQ-026 v_sync asserted for vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491 default) over the full line, independent of hc.
REQ-027 x, y, h_sync, v_sync, frame_active SHALL always be mutually consistent (decoded from the same counter pair).
REQ-028 line_start=1 for exactly one clk after loading hc=0; frame_start=1 only when also vc=0.
REQ-029 frame_ctr increments by 1 on the pix_en=1 clk where (hc,vc)=(H_TOTAL-1,V_TOTAL-1); 8-bit modulo wrap.
REQ-030 No output changes on a clk without pix_en=1, except line_start/frame_start returning to 0.

Reset
REQ-031 rst=1 on clk: hc=0, vc=0, x=0, y=0, frame_active=0, h_sync=v_sync=~SYNC_POL, line_start=0, frame_start=0, frame_ctr=0; rst overrides pix_en.
REQ-032 First pix_en=1 clk after rst release: x=0, y=0, frame_active=1, line_start=1, frame_start=1; hc=1.
REQ-033 rst asserted mid-frame (any hc,vc) SHALL return to REQ-031 state on that clk with no partial sync pulse extension.

Verification
REQ-034 Release rst, pix_en=1 constant -> cycle 1 after release: x=0,y=0,frame_active=1,frame_start=1; cycle 2: x=1,line_start=0,frame_start=0.
REQ-035 Free-run one line -> frame_active high 640 clks, h_sync low exactly 96 clks starting x=656, line_start period 800 clks.
REQ-036 Free-run one frame -> v_sync low for y=490..491 (1600 clks), frame_start period 420000 clks, frame_ctr 0->1 on wrap to (0,0).
REQ-037 pix_en toggled 1/0 alternately -> sequence of x,y identical to free-run, each value held 2 clks, line_start/frame_start width 1 clk.
REQ-038 Force 256 frames -> frame_ctr wraps 255->0; rst at x=700,y=491 -> next clk x=0,y=0,v_sync=h_sync=1,frame_ctr=0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel/line counters gated by a pixel
// tick, with registered coordinates, sync pulses, active-area flag and frame count.
module vga_timing_gen #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pix_en,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       frame_active,
   output logic       h_sync,
   output logic       v_sync,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] frame_ctr
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [9:0] hc;
   logic [9:0] vc;
   logic       h_last;
   logic       v_last;
   logic       hs_on;
   logic       vs_on;
   logic       active;

   // Every decoded output comes from the same (hc, vc) pair that loads x/y,
   // so the registered outputs always describe one and the same pixel.
   always_comb begin
      h_last = (hc == H_LAST);
      v_last = (vc == V_LAST);
      hs_on  = (hc >= HS_BEGIN) && (hc <= HS_END);
      vs_on  = (vc >= VS_BEGIN) && (vc <= VS_END);
      active = (hc < H_ACT) && (vc < V_ACT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hc           <= '0;
         vc           <= '0;
         x            <= '0;
         y            <= '0;
         frame_active <= 1'b0;
         h_sync       <= ~SYNC_POL;
         v_sync       <= ~SYNC_POL;
         line_start   <= 1'b0;
         frame_start  <= 1'b0;
         frame_ctr    <= '0;
      end else begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         if (pix_en) begin
            x            <= hc;
            y            <= vc;
            frame_active <= active;
            h_sync       <= hs_on ? SYNC_POL : ~SYNC_POL;
            v_sync       <= vs_on ? SYNC_POL : ~SYNC_POL;
            line_start   <= (hc == 10'd0);
            frame_start  <= (hc == 10'd0) && (vc == 10'd0);
            if (h_last) begin
               hc <= '0;
               if (v_last) begin
                  vc        <= '0;
                  frame_ctr <= frame_ctr + 8'd1;
               end else begin
                  vc <= vc + 10'd1;
               end
            end else begin
               hc <= hc + 10'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default-timing instance for line checks and a reduced-timing
// instance (16x8 totals) so whole frames and the 8-bit frame counter wrap fit in time.
module tb_vga_timing_gen;

   logic clk;
   logic rst;
   logic pix_en;

   logic [9:0] def_x, def_y;
   logic       def_fa, def_hs, def_vs, def_ls, def_fs;
   logic [7:0] def_fc;

   logic [9:0] sm_x, sm_y;
   logic       sm_fa, sm_hs, sm_vs, sm_ls, sm_fs;
   logic [7:0] sm_fc;

   int n_vec;
   int n_err;

   vga_timing_gen dut_def (
      .clk(clk), .rst(rst), .pix_en(pix_en),
      .x(def_x), .y(def_y), .frame_active(def_fa),
      .h_sync(def_hs), .v_sync(def_vs),
      .line_start(def_ls), .frame_start(def_fs), .frame_ctr(def_fc)
   );

   // Small raster: H = 8+2+3+3 = 16, V = 4+1+2+1 = 8, frame = 128 clks.
   // h_sync active for x 10..12, v_sync active for y 5..6.
   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
   ) dut_sm (
      .clk(clk), .rst(rst), .pix_en(pix_en),
      .x(sm_x), .y(sm_y), .frame_active(sm_fa),
      .h_sync(sm_hs), .v_sync(sm_vs),
      .line_start(sm_ls), .frame_start(sm_fs), .frame_ctr(sm_fc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      pix_en = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++;
      if ({def_x, def_y, def_fa, def_hs, def_vs, def_ls, def_fs, def_fc} !==
          {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
         n_err++;
         $display("FAIL reset_def: x=%0d y=%0d fa=%b hs=%b vs=%b ls=%b fs=%b fc=%0d, required 0 0 0 1 1 0 0 0",
                  def_x, def_y, def_fa, def_hs, def_vs, def_ls, def_fs, def_fc);
      end
      n_vec++;
      if ({sm_x, sm_y, sm_fa, sm_hs, sm_vs, sm_ls, sm_fs, sm_fc} !==
          {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
         n_err++;
         $display("FAIL reset_sm: x=%0d y=%0d fa=%b hs=%b vs=%b ls=%b fs=%b fc=%0d, required 0 0 0 1 1 0 0 0",
                  sm_x, sm_y, sm_fa, sm_hs, sm_vs, sm_ls, sm_fs, sm_fc);
      end
   endtask

   task automatic test_first_cycles();
      do_reset();
      step();
      n_vec++;
      if ({def_x, def_y, def_fa, def_ls, def_fs} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1}) begin
         n_err++;
         $display("FAIL first_clk: x=%0d y=%0d fa=%b ls=%b fs=%b, required 0 0 1 1 1",
                  def_x, def_y, def_fa, def_ls, def_fs);
      end
      step();
      n_vec++;
      if ({def_x, def_y, def_ls, def_fs} !== {10'd1, 10'd0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL second_clk: x=%0d y=%0d ls=%b fs=%b, required 1 0 0 0",
                  def_x, def_y, def_ls, def_fs);
      end
   endtask

   task automatic test_line();
      int x_err, fa_err, hs_err, ls_err, fa_cnt, hs_cnt, hs_first;
      x_err = 0; fa_err = 0; hs_err = 0; ls_err = 0;
      fa_cnt = 0; hs_cnt = 0; hs_first = -1;
      do_reset();
      for (int i = 0; i <= 800; i++) begin
         int ex;
         step();
         ex = i % 800;
         if (def_x !== 10'(ex)) x_err++;
         if (def_fa !== (ex < 640)) fa_err++;
         if (def_hs !== !(ex >= 656 && ex <= 751)) hs_err++;
         if (def_ls !== (ex == 0)) ls_err++;
         if (i < 800) begin
            if (def_fa === 1'b1) fa_cnt++;
            if (def_hs === 1'b0) begin
               hs_cnt++;
               if (hs_first < 0) hs_first = i;
            end
         end
      end
      n_vec++;
      if (x_err != 0) begin n_err++; $display("FAIL line_x: %0d bad clks, required 0", x_err); end
      n_vec++;
      if (fa_cnt != 640 || fa_err != 0) begin
         n_err++; $display("FAIL line_active: %0d high clks (%0d misplaced), required 640", fa_cnt, fa_err);
      end
      n_vec++;
      if (hs_cnt != 96 || hs_first != 656 || hs_err != 0) begin
         n_err++; $display("FAIL line_hsync: %0d low clks from x=%0d, required 96 from 656", hs_cnt, hs_first);
      end
      n_vec++;
      if (ls_err != 0) begin n_err++; $display("FAIL line_start_period: %0d bad clks, required 0", ls_err); end
   endtask

   task automatic test_frame();
      int xy_err, dec_err, fs_err, fc_err, vs_cnt;
      xy_err = 0; dec_err = 0; fs_err = 0; fc_err = 0; vs_cnt = 0;
      do_reset();
      for (int i = 0; i <= 256; i++) begin
         int ex, ey;
         step();
         ex = i % 16;
         ey = (i / 16) % 8;
         if ({sm_x, sm_y} !== {10'(ex), 10'(ey)}) xy_err++;
         if ({sm_fa, sm_hs, sm_vs, sm_ls} !==
             {(ex < 8 && ey < 4), !(ex >= 10 && ex <= 12), !(ey >= 5 && ey <= 6), (ex == 0)}) dec_err++;
         if (sm_fs !== (i % 128 == 0)) fs_err++;
         if (sm_fc !== 8'(((i + 1) / 128) % 256)) fc_err++;
         if (i < 128 && sm_vs === 1'b0) vs_cnt++;
      end
      n_vec++;
      if (xy_err != 0) begin n_err++; $display("FAIL frame_xy: %0d bad clks, required 0", xy_err); end
      n_vec++;
      if (dec_err != 0) begin n_err++; $display("FAIL frame_decode: %0d bad clks, required 0", dec_err); end
      n_vec++;
      if (vs_cnt != 32) begin n_err++; $display("FAIL frame_vsync: %0d low clks, required 32", vs_cnt); end
      n_vec++;
      if (fs_err != 0) begin n_err++; $display("FAIL frame_start_period: %0d bad clks, required 0", fs_err); end
      n_vec++;
      if (fc_err != 0) begin n_err++; $display("FAIL frame_ctr_step: %0d bad clks, required 0", fc_err); end
   endtask

   task automatic test_pix_en_toggle();
      int on_err, off_err;
      on_err = 0; off_err = 0;
      do_reset();
      for (int k = 0; k < 160; k++) begin
         int ex, ey;
         ex = k % 16;
         ey = (k / 16) % 8;
         pix_en = 1'b1;
         step();
         if ({sm_x, sm_y, sm_ls, sm_fs} !== {10'(ex), 10'(ey), (ex == 0), (k % 128 == 0)}) on_err++;
         pix_en = 1'b0;
         step();
         if ({sm_x, sm_y, sm_ls, sm_fs, sm_fc} !== {10'(ex), 10'(ey), 1'b0, 1'b0, 8'((k + 1) / 128)})
            off_err++;
      end
      pix_en = 1'b1;
      n_vec++;
      if (on_err != 0) begin n_err++; $display("FAIL toggle_advance: %0d bad clks, required 0", on_err); end
      n_vec++;
      if (off_err != 0) begin n_err++; $display("FAIL toggle_hold: %0d bad clks, required 0", off_err); end
   endtask

   task automatic test_wrap_and_mid_reset();
      do_reset();
      for (int i = 0; i <= 33134; i++) begin
         step();
         if (i == 32639) begin
            n_vec++;
            if (sm_fc !== 8'd255) begin n_err++; $display("FAIL fc_255: got %0d, required 255", sm_fc); end
         end
         if (i == 32767) begin
            n_vec++;
            if (sm_fc !== 8'd0) begin n_err++; $display("FAIL fc_wrap: got %0d, required 0", sm_fc); end
         end
      end
      // Now at x=14 (back porch) on line 6 (inside v_sync), two frames past the wrap.
      n_vec++;
      if ({sm_x, sm_y, sm_vs, sm_fc} !== {10'd14, 10'd6, 1'b0, 8'd2}) begin
         n_err++;
         $display("FAIL pre_mid_reset: x=%0d y=%0d vs=%b fc=%0d, required 14 6 0 2", sm_x, sm_y, sm_vs, sm_fc);
      end
      rst = 1'b1;
      step();
      n_vec++;
      if ({sm_x, sm_y, sm_fa, sm_hs, sm_vs, sm_ls, sm_fs, sm_fc} !==
          {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
         n_err++;
         $display("FAIL mid_reset: x=%0d y=%0d fa=%b hs=%b vs=%b fc=%0d, required 0 0 0 1 1 0",
                  sm_x, sm_y, sm_fa, sm_hs, sm_vs, sm_fc);
      end
      rst = 1'b0;
      step();
      n_vec++;
      if ({sm_x, sm_y, sm_vs, sm_fs} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
         n_err++;
         $display("FAIL after_mid_reset: x=%0d y=%0d vs=%b fs=%b, required 0 0 1 1", sm_x, sm_y, sm_vs, sm_fs);
      end
   endtask

   initial begin
      n_vec  = 0;
      n_err  = 0;
      rst    = 1'b1;
      pix_en = 1'b0;
      test_reset();
      test_first_cycles();
      test_line();
      test_frame();
      test_pix_en_toggle();
      test_wrap_and_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
